// File: rtl/dac_table_8x_hls_deadlock_report_unit.sv
// Deadlock report unit for dac_table_8x: debounces the monitor block flags and
// latches a sticky snapshot, then serialises the blocked monitor indices.
module dac_table_8x_hls_deadlock_report_unit #(
  parameter int NUM_MON = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 2
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               clear,
  output logic               deadlock,
  output logic [NUM_MON-1:0] snapshot,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic               rpt_last
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [NUM_MON-1:0] pend_r, pend_s;
  logic [NUM_MON-1:0] snapshot_r, snapshot_s;
  logic               deadlock_r, deadlock_s;
  logic               any_block_s;
  logic               report_s;
  logic               last_s;
  logic [IDX_W-1:0]   low_idx_s;

  // Index of the lowest set bit; zero for an empty vector.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_MON-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      r = v[i] ? IDX_W'(i) : r;
    end
    return r;
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic is_single(input logic [NUM_MON-1:0] v);
    return (v != '0) && ((v & (v - NUM_MON'(1))) == '0);
  endfunction

  assign any_block_s = |mon_block;
  assign report_s    = (state_r == ST_REPORT);
  assign low_idx_s   = lowest_idx(pend_r);
  assign last_s      = is_single(pend_r);

  // Report channel is driven from pend and state only, never from rpt_ready.
  assign rpt_valid = report_s;
  assign rpt_idx   = report_s ? low_idx_s : '0;
  assign rpt_last  = report_s & last_s;
  assign deadlock  = deadlock_r;
  assign snapshot  = snapshot_r;

  // Next-state logic: clear wins over everything, then per-state behaviour.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    pend_s     = pend_r;
    snapshot_s = snapshot_r;
    deadlock_s = deadlock_r;
    if (clear) begin
      state_s    = ST_IDLE;
      cnt_s      = '0;
      pend_s     = '0;
      snapshot_s = '0;
      deadlock_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_block_s) begin
            state_s = ST_COUNT;
            cnt_s   = CNT_W'(1);
          end else begin
            cnt_s   = '0;
          end
        end
        ST_COUNT: begin
          if (!any_block_s) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            // Confirming edge: cnt stays at TIMEOUT-1 from here on.
            state_s    = ST_REPORT;
            snapshot_s = mon_block;
            pend_s     = mon_block;
            deadlock_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_REPORT: begin
          if (rpt_ready) begin
            pend_s = pend_r & (pend_r - NUM_MON'(1));
            if (last_s) begin
              state_s = ST_HOLD;
            end else begin
              state_s = ST_REPORT;
            end
          end else begin
            pend_s = pend_r;
          end
        end
        ST_HOLD: begin
          state_s = ST_HOLD;
        end
        default: begin
          state_s    = ST_IDLE;
          cnt_s      = '0;
          pend_s     = '0;
          snapshot_s = '0;
          deadlock_s = 1'b0;
        end
      endcase
    end
  end

  // State and sticky result registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      pend_r     <= '0;
      snapshot_r <= '0;
      deadlock_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      pend_r     <= pend_s;
      snapshot_r <= snapshot_s;
      deadlock_r <= deadlock_s;
    end
  end

endmodule

// File: tb/tb_dac_table_8x_hls_deadlock_report_unit.sv
// Bench for the deadlock report unit: directed scenarios plus random stimulus,
// checked every cycle against a run-length / index-queue reference model.
module tb_dac_table_8x_hls_deadlock_report_unit;

  localparam int NUM_MON = 4;
  localparam int TIMEOUT = 8;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n;
  logic [NUM_MON-1:0] mon_block;
  logic               clear;
  logic               deadlock;
  logic [NUM_MON-1:0] snapshot;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [1:0]         rpt_idx;
  logic               rpt_last;

  int checks_n = 0;
  int errors_n = 0;

  // Reference model: consecutive blocked edges, sticky flag, queue of indices.
  int                 m_run;
  bit                 m_dl;
  logic [NUM_MON-1:0] m_snap;
  int                 m_q[$];

  dac_table_8x_hls_deadlock_report_unit #(
    .NUM_MON(NUM_MON),
    .TIMEOUT(TIMEOUT),
    .CNT_W(16),
    .IDX_W(2)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .mon_block(mon_block),
    .clear(clear),
    .deadlock(deadlock),
    .snapshot(snapshot),
    .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready),
    .rpt_idx(rpt_idx),
    .rpt_last(rpt_last)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_dl   = 1'b0;
    m_snap = '0;
    m_q.delete();
  endtask

  task automatic model_step(input logic [NUM_MON-1:0] mb, input logic clr, input logic rdy);
    if (clr) begin
      model_reset();
    end else if (!m_dl) begin
      if (mb != '0) begin
        m_run++;
        if (m_run == TIMEOUT) begin
          m_dl   = 1'b1;
          m_snap = mb;
          for (int i = 0; i < NUM_MON; i++) if (mb[i]) m_q.push_back(i);
        end
      end else begin
        m_run = 0;
      end
    end else if (m_q.size() > 0 && rdy) begin
      void'(m_q.pop_front());
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = m_dl && (m_q.size() > 0);
    check_eq("deadlock", 32'(deadlock), 32'(m_dl));
    check_eq("snapshot", 32'(snapshot), 32'(m_snap));
    check_eq("rpt_valid", 32'(rpt_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_eq("rpt_idx", 32'(rpt_idx), 32'(m_q[0]));
      check_eq("rpt_last", 32'(rpt_last), 32'(m_q.size() == 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_deadlock"}, 32'(deadlock), 32'd0);
    check_eq({tag, "_snapshot"}, 32'(snapshot), 32'd0);
    check_eq({tag, "_rpt_valid"}, 32'(rpt_valid), 32'd0);
    check_eq({tag, "_rpt_idx"}, 32'(rpt_idx), 32'd0);
    check_eq({tag, "_rpt_last"}, 32'(rpt_last), 32'd0);
  endtask

  // One cycle: check current outputs, then drive the inputs for the next edge.
  task automatic cyc(input logic [NUM_MON-1:0] mb, input logic clr, input logic rdy);
    @(negedge ap_clk);
    check_outputs();
    mon_block = mb;
    clear     = clr;
    rpt_ready = rdy;
    model_step(mb, clr, rdy);
  endtask

  task automatic async_reset(input string tag);
    @(negedge ap_clk);
    check_outputs();
    #2 ap_rst_n = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    mon_block = '0;
    clear     = 1'b0;
    rpt_ready = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rdy_pat;
    ap_rst_n  = 1'b0;
    mon_block = '0;
    clear     = 1'b0;
    rpt_ready = 1'b0;
    model_reset();
    #1 check_all_zero("reset");
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single monitor held: confirm on the 8th edge, one beat, then hold.
    for (int i = 0; i < 12; i++) cyc(4'b0010, 1'b0, 1'b1);
    cyc(4'b0000, 1'b1, 1'b0);

    // Gap after 7 blocked cycles restarts the count.
    for (int i = 0; i < 7; i++) cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(4'b0010, 1'b0, 1'b1);
    cyc(4'b0000, 1'b1, 1'b0);

    // Alternating monitors with no gap still confirm.
    for (int i = 0; i < 10; i++) cyc((i % 2) ? 4'b1000 : 4'b0001, 1'b0, 1'b1);
    cyc(4'b0000, 1'b1, 1'b0);

    // Three-beat report under back-pressure 0,1,0,0,1,1.
    for (int i = 0; i < 8; i++) cyc(4'b1011, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rdy_pat = 4'((6'b110010 >> i) & 6'b000001);
      cyc(4'b0100, 1'b0, rdy_pat[0]);
    end
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b1, 1'b0);

    // Clear during report after the first beat, then re-detect.
    for (int i = 0; i < 8; i++) cyc(4'b1011, 1'b0, 1'b0);
    cyc(4'b1011, 1'b0, 1'b1);
    cyc(4'b1011, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) cyc(4'b0110, 1'b0, 1'b1);
    cyc(4'b0000, 1'b1, 1'b0);

    // Asynchronous reset mid-count and mid-hold.
    for (int i = 0; i < 4; i++) cyc(4'b0100, 1'b0, 1'b0);
    async_reset("rst_count");
    for (int i = 0; i < 12; i++) cyc(4'b1001, 1'b0, 1'b1);
    async_reset("rst_hold");
    for (int i = 0; i < 10; i++) cyc(4'b0001, 1'b0, 1'b1);

    // Random traffic; mostly blocked so confirmations happen often.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] mb;
      logic       clr;
      mb  = ($urandom_range(0, 11) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      clr = ($urandom_range(0, 39) == 0);
      cyc(mb, clr, 1'($urandom_range(0, 1)));
    end
    cyc(4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/dac_table_8x_hls_deadlock_report_unit.md
Name: dac_table_8x_hls_deadlock_report_unit

Overview:
Consumer end of the per-instance HLS deadlock monitors. It collects the `block` flags from up to NUM_MON monitors and debounces them with a consecutive-cycle timeout. On a confirmed deadlock it latches a sticky snapshot of which monitors were blocked. It then serialises the indices of the blocked monitors over a valid/ready report channel to the debug/status logic of dac_table_8x.

Parameters:
NUM_MON, 4, number of monitor block inputs (>=1)
TIMEOUT, 1024, consecutive blocked cycles required to declare deadlock (>=2)
CNT_W, 16, width of the persistence counter; must satisfy 2^CNT_W > TIMEOUT
IDX_W, 2, width of rpt_idx; equals max(1, clog2(NUM_MON))

Ports:
ap_clk  in  1  single clock; all logic on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
mon_block  in  NUM_MON  block output of each deadlock monitor, bit i = monitor i
clear  in  1  single-cycle request to discard the detection and re-arm
deadlock  out  1  sticky flag: a deadlock has been confirmed
snapshot  out  NUM_MON  mon_block value captured at confirmation; sticky
rpt_valid  out  1  report beat valid
rpt_ready  in  1  report sink ready
rpt_idx  out  IDX_W  index of the blocked monitor carried in this beat
rpt_last  out  1  final beat of the report

Behaviour:
- Reset is ap_rst_n low, asynchronous. It forces state=IDLE, cnt=0 and pend=0. All outputs are 0 (deadlock, snapshot, rpt_valid, rpt_idx, rpt_last).
- any_block = OR of mon_block.
- clear has priority over every other condition in every state. On the next edge it forces IDLE and zeroes cnt, pend, deadlock, snapshot, rpt_valid and rpt_last.
- State IDLE: cnt=0.
  - any_block=1 -> COUNT with cnt=1.
- State COUNT:
  - any_block=0 -> IDLE with cnt=0; no partial credit is kept.
  - any_block=1 and cnt==TIMEOUT-1 -> REPORT. On that edge: snapshot<=mon_block, pend<=mon_block, deadlock<=1.
  - Otherwise cnt<=cnt+1.
  - Net effect: deadlock rises after the TIMEOUT-th consecutive edge that samples any_block=1.
  - The monitor set may change between cycles; only the OR must stay high.
- State REPORT:
  - rpt_valid=1.
  - rpt_idx = lowest set bit of pend.
  - rpt_last = 1 when pend has exactly one set bit.
  - On rpt_valid&rpt_ready, the reported bit is cleared from pend.
  - If the transfer had rpt_last=1 -> HOLD, and rpt_valid falls on the next cycle.
  - While rpt_valid=1 and rpt_ready=0, rpt_idx and rpt_last stay stable.
  - One beat per set bit, in ascending index order. Throughput is 1 beat/cycle when rpt_ready is held high.
  - pend is never zero on entry, because any_block=1 at capture.
- State HOLD:
  - deadlock and snapshot are held and rpt_valid=0.
  - mon_block is ignored.
  - Only clear or reset leaves HOLD.
- mon_block changes after confirmation do not alter snapshot, pend or deadlock.
- clear during REPORT abandons the report: rpt_valid drops on the next cycle even with a beat outstanding. The sink must tolerate this.
- Report outputs are combinational from pend and state only, with no rpt_ready-to-rpt_valid combinational path. All other outputs are registered.
- cnt saturates structurally at TIMEOUT-1 and never wraps.

Test Plan:
- TIMEOUT=8, NUM_MON=4, mon_block=4'b0010 held → deadlock=1 after the 8th sampled edge (not the 7th); snapshot=0010; one beat idx=1, last=1 with rpt_ready=1; then HOLD with rpt_valid=0.
- mon_block=0010 for 7 cycles, 0 for 1 cycle, then 0010 again → no deadlock until 8 further consecutive cycles; counter restarts at 1.
- mon_block alternating between 0001 and 1000 every cycle with no gap → deadlock after 8 cycles; snapshot = value on the confirming edge.
- snapshot=1011, rpt_ready pattern 0,1,0,0,1,1 → beats idx 0,1,3 with last only on idx 3; idx/last stable during stalls; pend empty afterwards.
- clear pulse during REPORT after the first beat → next cycle rpt_valid=0, deadlock=0, snapshot=0; re-detection works after a further 8 blocked cycles.
- ap_rst_n asserted asynchronously mid-COUNT and mid-HOLD → outputs 0 immediately without waiting for a clock edge; after release, the block behaves as from IDLE.
